// File: rtl/apb_spi_arbiter.sv
// apb_spi_arbiter
//
// Round-robin APB master that shares the single APB slave port of the
// APB-to-SPI bridge among NREQ local requesters. One requester's command is
// latched at grant time, a full APB setup/access transfer is run, and the
// read data and error status are returned with a one-cycle done pulse to that
// requester. A watchdog aborts an access phase that PREADY never completes.
//
// Ports:
//   PCLK         in   APB clock, rising edge
//   resetn       in   asynchronous reset, active high
//   req          in   [NREQ]        per-requester request level
//   req_write    in   [NREQ]        per-requester direction (1 = write)
//   req_addr     in   [NREQ*WIDTH]  per-requester address, slice i at [i*WIDTH +: WIDTH]
//   req_wdata    in   [NREQ*WIDTH]  per-requester write data, packed like req_addr
//   done         out  [NREQ]        one-hot completion pulse
//   rdata        out  [WIDTH]       read data, valid while done is high
//   err          out                PSLVERR or watchdog error, valid while done is high
//   timeout_err  out                transfer aborted by the watchdog, valid while done is high
//   busy         out                high in SETUP and ACCESS
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   out  APB master signals
//   PREADY, PSLVERR, PRDATA                in   APB slave responses

module apb_spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    PCLK,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*WIDTH-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        rdata,
  output logic                    err,
  output logic                    timeout_err,
  output logic                    busy,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [WIDTH-1:0]        PADDR,
  output logic [WIDTH-1:0]        PWDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [WIDTH-1:0]        PRDATA
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Last ACCESS cycle allowed before the watchdog fires: the counter is 0 in
  // the first ACCESS cycle, so the access phase lasts at most TIMEOUT cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] grant_next_ptr;
  logic            grant_valid;
  logic            take_grant;
  logic            finish;
  logic            timed_out;
  logic [7:0]      wd_cnt;

  // (base + off) modulo NREQ, for off in 0..NREQ-1.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDXW'(sum);
  endfunction

  // Round-robin search starting at rr_ptr. Iterating from the farthest offset
  // down to zero lets the nearest set request overwrite the others.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrap_add(rr_ptr, i)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign grant_next_ptr = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);

  always_ff @(posedge PCLK or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_next;
  end

  // PREADY is tested before the watchdog so a response arriving in the last
  // allowed ACCESS cycle completes normally.
  always_comb begin
    state_next = state;
    take_grant = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          take_grant = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        PSEL       = 1'b1;
        busy       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        busy    = 1'b1;
        if (PREADY) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, round-robin pointer, watchdog and completion reporting.
  // The command is captured only at grant, so requester inputs may change
  // freely once a transfer has started.
  always_ff @(posedge PCLK or posedge resetn) begin
    if (resetn) begin
      rr_ptr      <= '0;
      owner       <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      wd_cnt      <= '0;
      done        <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= '0;
      if (take_grant) begin
        owner  <= grant_idx;
        rr_ptr <= grant_next_ptr;
        PWRITE <= req_write[grant_idx];
        PADDR  <= req_addr[grant_idx*WIDTH +: WIDTH];
        PWDATA <= req_wdata[grant_idx*WIDTH +: WIDTH];
      end
      if (state == SETUP)       wd_cnt <= '0;
      else if (state == ACCESS) wd_cnt <= wd_cnt + 8'd1;
      if (finish) begin
        done[owner] <= 1'b1;
        err         <= timed_out ? 1'b1 : PSLVERR;
        timeout_err <= timed_out;
        if (!timed_out && !PWRITE) rdata <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// tb_apb_spi_arbiter
//
// Self-checking bench for apb_spi_arbiter (NREQ=4, WIDTH=8, TIMEOUT=48).
// A directed table of transfers covers the single write/read, round-robin,
// re-request, timeout, timeout-cycle PREADY and PSLVERR cases; a hand-written
// sequence covers reset in mid-transfer; a randomized section checks against
// a transaction-level model (round-robin pick, access length, error/rdata).

module tb_apb_spi_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 48;

  logic                  PCLK = 1'b0;
  logic                  resetn;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      rdata;
  logic                  err;
  logic                  timeout_err;
  logic                  busy;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [WIDTH-1:0]      PADDR;
  logic [WIDTH-1:0]      PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [WIDTH-1:0]      PRDATA;

  always #5 PCLK = ~PCLK;

  apb_spi_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK        (PCLK),
    .resetn      (resetn),
    .req         (req),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .timeout_err (timeout_err),
    .busy        (busy),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester-side state and reference model state.
  logic [NREQ-1:0]  req_v;
  logic             r_write [NREQ];
  logic [WIDTH-1:0] r_addr  [NREQ];
  logic [WIDTH-1:0] r_wdata [NREQ];
  int               mdl_ptr;
  logic [WIDTH-1:0] mdl_rdata;

  typedef struct {
    logic [3:0] req_set;
    logic [3:0] keep;
    int         wait_n;
    logic       slverr;
    logic [7:0] prd;
    int         exp_grant;
    logic       exp_err;
    logic       exp_tmo;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic applyStimulus();
    req = req_v;
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]                 = r_write[i];
      req_addr[i*WIDTH +: WIDTH]   = r_addr[i];
      req_wdata[i*WIDTH +: WIDTH]  = r_wdata[i];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
    r_write[i] = w;
    r_addr[i]  = a;
    r_wdata[i] = d;
  endtask

  // First set request at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int off = 0; off < NREQ; off++)
      if (r[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    resetn  = 1'b1;
    req_v   = '0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    applyStimulus();
    tick();
    tick();
    resetn    = 1'b0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
  endtask

  // One complete transfer, starting from a cycle in which the DUT is idle and
  // req has just been driven. The slave raises PREADY in ACCESS cycle wait_n
  // (0-based); wait_n >= TIMEOUT means it never answers.
  task automatic run_one(input int g, input int wait_n, input logic slverr,
                         input logic [7:0] prd, input logic exp_err,
                         input logic exp_tmo, input logic [7:0] exp_rd,
                         input logic keep);
    logic [2*WIDTH:0] exp_cmd;
    logic [NREQ-1:0]  exp_done;
    int               exp_len;
    exp_cmd     = {r_write[g], r_addr[g], r_wdata[g]};
    exp_len     = (wait_n < TIMEOUT) ? wait_n + 1 : TIMEOUT;
    exp_done    = '0;
    exp_done[g] = 1'b1;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;
    tick();
    checkOutput("setup_ctl", 32'({PSEL, PENABLE, busy, |done}), 32'(4'b1010));
    checkOutput("setup_cmd", 32'({PWRITE, PADDR, PWDATA}), 32'(exp_cmd));
    tick();
    for (int j = 0; j < exp_len; j++) begin
      if (j > 0) tick();
      checkOutput("access_ctl", 32'({PSEL, PENABLE, busy, |done}), 32'(4'b1110));
      checkOutput("access_cmd", 32'({PWRITE, PADDR, PWDATA}), 32'(exp_cmd));
      PREADY  = (j == wait_n);
      PSLVERR = PREADY ? slverr : 1'($urandom_range(0, 1));
      PRDATA  = PREADY ? prd : 8'($urandom);
    end
    tick();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    checkOutput("done_onehot", 32'(done), 32'(exp_done));
    checkOutput("done_status", 32'({err, timeout_err}), 32'({exp_err, exp_tmo}));
    checkOutput("done_rdata", 32'(rdata), 32'(exp_rd));
    checkOutput("done_busctl", 32'({PSEL, PENABLE, busy}), 32'(3'b000));
    mdl_ptr   = (g + 1) % NREQ;
    mdl_rdata = exp_rd;
    req_v[g]  = keep;
    applyStimulus();
    if (done !== exp_done) do_reset();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [NREQ-1:0] newreq;
    int              g, wait_n, sel;
    logic            slverr, keep, tmo, e_err;
    logic [7:0]      prd, e_rd;

    // Directed transfer table: {req_set, keep, wait, slverr, prd, grant, err, tmo, rdata}
    vecs[0]  = '{4'b0001, 4'b0000, 39,          1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{4'b0100, 4'b0000, 2,           1'b0, 8'h4A, 2, 1'b0, 1'b0, 8'h4A};
    vecs[2]  = '{4'b1000, 4'b0000, 0,           1'b0, 8'h5C, 3, 1'b0, 1'b0, 8'h5C};
    vecs[3]  = '{4'b1111, 4'b0000, 0,           1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h5C};
    vecs[4]  = '{4'b0000, 4'b0000, 1,           1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h5C};
    vecs[5]  = '{4'b0000, 4'b0000, 3,           1'b0, 8'h96, 2, 1'b0, 1'b0, 8'h96};
    vecs[6]  = '{4'b0000, 4'b0000, 0,           1'b0, 8'h0F, 3, 1'b0, 1'b0, 8'h0F};
    vecs[7]  = '{4'b1001, 4'b1001, 0,           1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h0F};
    vecs[8]  = '{4'b0000, 4'b1001, 0,           1'b0, 8'h3C, 3, 1'b0, 1'b0, 8'h3C};
    vecs[9]  = '{4'b0000, 4'b1001, 1,           1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h3C};
    vecs[10] = '{4'b0000, 4'b0001, 0,           1'b0, 8'hA5, 3, 1'b0, 1'b0, 8'hA5};
    vecs[11] = '{4'b0000, 4'b0000, 0,           1'b0, 8'h00, 0, 1'b0, 1'b0, 8'hA5};
    vecs[12] = '{4'b0010, 4'b0000, TIMEOUT,     1'b0, 8'h00, 1, 1'b1, 1'b1, 8'hA5};
    vecs[13] = '{4'b0010, 4'b0000, TIMEOUT - 1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 8'hA5};
    vecs[14] = '{4'b0100, 4'b0000, 1,           1'b1, 8'h77, 2, 1'b1, 1'b0, 8'h77};
    vecs[15] = '{4'b1000, 4'b0000, 60,          1'b0, 8'h00, 3, 1'b1, 1'b1, 8'h77};

    set_cmd(0, 1'b1, 8'hAA, 8'h55);
    set_cmd(1, 1'b1, 8'h31, 8'hC3);
    set_cmd(2, 1'b0, 8'hAA, 8'h3F);
    set_cmd(3, 1'b0, 8'h7E, 8'h00);
    req_v   = '0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    resetn  = 1'b1;
    applyStimulus();
    tick();
    tick();
    checkOutput("reset_ctl", 32'({PSEL, PENABLE, busy, PWRITE, err, timeout_err}), 32'(0));
    checkOutput("reset_data", 32'({done, rdata, PADDR, PWDATA}), 32'(0));
    resetn    = 1'b0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
    tick();
    checkOutput("idle_no_req", 32'({PSEL, busy, |done}), 32'(0));

    for (int v = 0; v < 16; v++) begin
      req_v = req_v | vecs[v].req_set;
      applyStimulus();
      run_one(vecs[v].exp_grant, vecs[v].wait_n, vecs[v].slverr, vecs[v].prd,
              vecs[v].exp_err, vecs[v].exp_tmo, vecs[v].exp_rdata,
              vecs[v].keep[vecs[v].exp_grant]);
    end

    // Reset asserted asynchronously in the middle of an ACCESS phase.
    req_v = 4'b0010;
    applyStimulus();
    tick();
    checkOutput("rstseq_setup", 32'({PSEL, PENABLE}), 32'(2'b10));
    tick();
    checkOutput("rstseq_access", 32'({PSEL, PENABLE}), 32'(2'b11));
    tick();
    #2 resetn = 1'b1;
    #1;
    checkOutput("rst_async_ctl", 32'({PSEL, PENABLE, busy, PWRITE, err, timeout_err}), 32'(0));
    checkOutput("rst_async_data", 32'({done, rdata, PADDR, PWDATA}), 32'(0));
    tick();
    checkOutput("rst_no_done", 32'({done, PSEL}), 32'(0));
    req_v = 4'b0101;
    applyStimulus();
    resetn    = 1'b0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
    run_one(0, 2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    run_one(2, 0, 1'b0, 8'hE1, 1'b0, 1'b0, 8'hE1, 1'b0);

    // Randomized transfers against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      newreq = 4'($urandom_range(0, 15)) & ~req_v;
      if ((req_v | newreq) == '0) newreq[$urandom_range(0, NREQ - 1)] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (newreq[i])
          set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      req_v = req_v | newreq;
      applyStimulus();
      g   = rr_pick(req_v, mdl_ptr);
      sel = $urandom_range(0, 9);
      if (sel < 7)      wait_n = $urandom_range(0, 5);
      else if (sel < 9) wait_n = TIMEOUT - 1 + $urandom_range(0, 1);
      else              wait_n = TIMEOUT + 10;
      slverr = 1'($urandom_range(0, 1));
      prd    = 8'($urandom);
      keep   = 1'($urandom_range(0, 1));
      tmo    = (wait_n >= TIMEOUT);
      e_err  = tmo | slverr;
      e_rd   = (!tmo && !r_write[g]) ? prd : mdl_rdata;
      run_one(g, wait_n, slverr, prd, e_err, tmo, e_rd, keep);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_spi_arbiter.md
# apb_spi_arbiter

Round-robin APB master that shares the single APB slave port of the APB-to-SPI bridge among NREQ local requesters. It latches one requester's command, runs a complete APB setup/access transfer, and returns PRDATA and error status to that requester. A watchdog aborts any access phase that PREADY never completes. The block sits between requester logic and the bridge, on the PCLK domain.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: APB address and data width.
- TIMEOUT, 255: maximum access-phase cycles to wait for PREADY (1..255).

Ports:
- PCLK  in  1  APB clock; all logic is on the rising edge.
- resetn  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; held high until the matching done bit pulses.
- req_write  in  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NREQ*WIDTH  per-requester address; slice i is bits [i*WIDTH +: WIDTH].
- req_wdata  in  NREQ*WIDTH  per-requester write data, packed the same way.
- done  out  NREQ  one-cycle completion pulse, one-hot.
- rdata  out  WIDTH  read data; valid while done is high.
- err  out  1  error flag; valid while done is high. Set by PSLVERR or by timeout.
- timeout_err  out  1  valid while done is high; 1 = transfer aborted by the watchdog.
- busy  out  1  high in the SETUP and ACCESS states.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR, PWDATA  out  WIDTH each  APB master address and write data.
- PREADY, PSLVERR  in  1 each  APB slave responses.
- PRDATA  in  WIDTH  APB slave read data.

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset state is IDLE.
- IDLE: if any req bit is set, grant the first set bit at or after rr_ptr, searching upward and wrapping from NREQ-1 to 0. On grant:
  - latch the grantee's index, req_write, req_addr and req_wdata into PWRITE, PADDR and PWDATA;
  - set rr_ptr to (grantee + 1) mod NREQ;
  - go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Clear the watchdog counter. Go to ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. The watchdog counter increments every cycle.
  - PREADY=1 sampled: capture PRDATA into rdata (reads only; rdata keeps its old value on writes) and PSLVERR into err. Pulse done[grantee]. Go to IDLE.
  - Counter reaches TIMEOUT with PREADY=0: pulse done[grantee] with err=1, timeout_err=1. Go to IDLE. The bridge sees PSEL fall.
  - If PREADY and the timeout occur in the same cycle, PREADY wins: normal completion, timeout_err=0.
- PADDR, PWDATA and PWRITE hold their latched values from SETUP through the end of ACCESS. Requester inputs are not sampled after the grant.
- If the grantee drops req mid-transfer, the transfer still completes and done still pulses.
- Requests that arrive while busy wait. Arbitration happens only in IDLE.
- rr_ptr resets to 0, so requester 0 has priority on the first grant after reset.
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, rdata, err, timeout_err and busy are all 0. Reset asserted mid-transfer clears them immediately (asynchronous) and aborts the transfer without a done pulse.

## Timing
- req seen at rising edge k in IDLE: SETUP during cycle k+1 (PSEL=1), ACCESS from cycle k+2 (PENABLE=1).
- PREADY sampled high at edge m: during cycle m+1, done=1, rdata and err are valid, and PSEL=PENABLE=0.
- Minimum transfer length (PREADY high in the first ACCESS cycle) is 3 cycles from the IDLE grant edge to the done pulse. The next grant is evaluated on the edge that ends the done cycle.
- Back-to-back transfers from different requesters therefore have exactly one idle bus cycle between them (PSEL=0).
- Watchdog: done with timeout_err arrives TIMEOUT cycles after the first ACCESS cycle.

## Test plan
- Single write: req[0]=1, addr 0xAA, wdata 0x55, bridge PREADY after 40 cycles -> one SETUP cycle, PADDR=0xAA and PWDATA=0x55 stable, done[0] pulses one cycle with err=0.
- Single read: req[2] read at 0xAA, slave returns PRDATA=0x4A with PREADY -> done[2] with rdata=0x4A, PWRITE=0 throughout.
- Round-robin: req=4'b1111 held, each requester drops req after its own done -> grant order 0,1,2,3, with one idle cycle between transfers.
- Round-robin, re-requesting: req[0] and req[3] both re-request continuously -> grants alternate 0,3,0,3.
- Timeout: TIMEOUT=16, PREADY held 0 -> done[1] 16 cycles into ACCESS with err=1, timeout_err=1, PSEL=0 the next cycle. Also check that PREADY arriving in the timeout cycle gives a normal completion.
- PSLVERR and reset: PREADY=1 with PSLVERR=1 -> done with err=1, timeout_err=0. resetn pulsed during ACCESS -> all outputs 0 immediately, no done pulse, and requester 0 wins the first grant after reset.
